// File: rtl/ahb3lite_traffic_gen.sv
// Self-checking AHB3-Lite master: writes NUM_WORDS words of pattern^addr from BASE_ADDR,
// reads them back and counts mismatches; supports INCR bursts, single transfers and ERROR aborts.
module ahb3lite_traffic_gen #(
    parameter int          HADDR_SIZE  = 16,
    parameter int          HDATA_SIZE  = 32,
    parameter int unsigned BASE_ADDR   = 'h0000,
    parameter int          NUM_WORDS   = 64,
    parameter int          IDLE_CYCLES = 0,
    parameter int          ERR_W       = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    input  logic                  burst_en,
    input  logic [HDATA_SIZE-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  bus_err,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [HADDR_SIZE-1:0] first_err,
    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int BYTES = HDATA_SIZE / 8;
    localparam int IDXW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int ICW   = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(NUM_WORDS - 1);
    localparam logic [HADDR_SIZE-1:0] BASE     = HADDR_SIZE'(BASE_ADDR);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [2:0] {IDLE, WRITE, WR_LAST, READ, RD_LAST, DONE} state_t;

    state_t                  state_q;
    logic                    burst_q;
    logic [HDATA_SIZE-1:0]   pattern_q;
    logic [IDXW-1:0]         idx_q;
    logic [ICW-1:0]          idleCnt_q;
    logic                    dphRead_q;
    logic [HADDR_SIZE-1:0]   dphAddr_q;
    logic                    busy_q, done_q, busErr_q;
    logic [ERR_W-1:0]        errCnt_q;
    logic [HADDR_SIZE-1:0]   firstErr_q;
    logic                    hsel_q, hwrite_q;
    logic [HADDR_SIZE-1:0]   haddr_q;
    logic [HDATA_SIZE-1:0]   hwdata_q;
    logic [2:0]              hburst_q;
    logic [1:0]              htrans_q;

    logic [HADDR_SIZE-1:0]   addrNext_d;
    logic                    rdMismatch_d;

    always_comb begin
        addrNext_d   = haddr_q + HADDR_SIZE'(BYTES);
        rdMismatch_d = dphRead_q && (HRDATA != (pattern_q ^ HDATA_SIZE'(dphAddr_q)));
    end

    // Every bus output is a register; nothing moves while HREADY is low except the
    // first ERROR cycle, which forces IDLE to cancel the already pipelined beat.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= IDLE;
            burst_q    <= 1'b0;
            pattern_q  <= '0;
            idx_q      <= '0;
            idleCnt_q  <= '0;
            dphRead_q  <= 1'b0;
            dphAddr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            busErr_q   <= 1'b0;
            errCnt_q   <= '0;
            firstErr_q <= '0;
            hsel_q     <= 1'b0;
            hwrite_q   <= 1'b0;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            hburst_q   <= 3'b000;
            htrans_q   <= TR_IDLE;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        burst_q    <= burst_en;
                        pattern_q  <= pattern;
                        busErr_q   <= 1'b0;
                        errCnt_q   <= '0;
                        firstErr_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= WRITE;
                        idx_q      <= '0;
                        idleCnt_q  <= '0;
                        dphRead_q  <= 1'b0;
                        hsel_q     <= 1'b1;
                        hwrite_q   <= 1'b1;
                        haddr_q    <= BASE;
                        hburst_q   <= burst_en ? 3'b001 : 3'b000;
                        htrans_q   <= TR_NONSEQ;
                    end
                end
                DONE: state_q <= IDLE;
                default: begin
                    if (busErr_q) begin
                        if (HREADY) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else if (HRESP && !HREADY) begin
                        busErr_q <= 1'b1;
                        htrans_q <= TR_IDLE;
                        hsel_q   <= 1'b0;
                    end else if (HREADY) begin
                        if (rdMismatch_d) begin
                            if (errCnt_q != '1)
                                errCnt_q <= errCnt_q + ERR_W'(1);
                            if (errCnt_q == '0)
                                firstErr_q <= dphAddr_q;
                        end
                        dphRead_q <= 1'b0;
                        case (state_q)
                            WRITE, READ: begin
                                if (htrans_q != TR_IDLE) begin
                                    if (state_q == WRITE) begin
                                        hwdata_q <= pattern_q ^ HDATA_SIZE'(haddr_q);
                                    end else begin
                                        dphRead_q <= 1'b1;
                                        dphAddr_q <= haddr_q;
                                    end
                                    if (idx_q == LAST_IDX) begin
                                        htrans_q <= TR_IDLE;
                                        hsel_q   <= 1'b0;
                                        state_q  <= (state_q == WRITE) ? WR_LAST : RD_LAST;
                                    end else begin
                                        idx_q   <= idx_q + IDXW'(1);
                                        haddr_q <= addrNext_d;
                                        // A burst may not cross a 1KB boundary, so restart it there
                                        if (burst_q) begin
                                            htrans_q <= (addrNext_d[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                                        end else if (IDLE_CYCLES == 0) begin
                                            htrans_q <= TR_NONSEQ;
                                        end else begin
                                            htrans_q  <= TR_IDLE;
                                            hsel_q    <= 1'b0;
                                            idleCnt_q <= ICW'(IDLE_CYCLES);
                                        end
                                    end
                                end else if (idleCnt_q <= ICW'(1)) begin
                                    htrans_q <= TR_NONSEQ;
                                    hsel_q   <= 1'b1;
                                end else begin
                                    idleCnt_q <= idleCnt_q - ICW'(1);
                                end
                            end
                            WR_LAST: begin
                                state_q  <= READ;
                                idx_q    <= '0;
                                haddr_q  <= BASE;
                                hwrite_q <= 1'b0;
                                hsel_q   <= 1'b1;
                                htrans_q <= TR_NONSEQ;
                            end
                            RD_LAST: begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bus_err   = busErr_q;
    assign err_cnt   = errCnt_q;
    assign first_err = firstErr_q;
    assign HSEL      = hsel_q;
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = 3'($clog2(BYTES));
    assign HBURST    = hburst_q;
    assign HPROT     = 4'b0011;
    assign HTRANS    = htrans_q;
    assign HMASTLOCK = 1'b0;

endmodule
